// File: rtl/step_sequencer.sv
// Step sequencer: STEPS x TRACKS pattern memory with edit port, tempo-driven
// playback, raw pad pass-through and per-track muting.
//
// Ports:
//   clk, rst      system clock / asynchronous active-high reset
//   mode          0=EDIT, 1=PLAY, 2=RAW, 3=PAUSE
//   tempo_lim     step period minus one, in clk cycles
//   seq_len       active pattern length (0 or >STEPS selects STEPS)
//   edit_idx      step selected for editing and for edit_row display
//   tgl           per-track toggle mask, applied on tgl_strobe
//   tgl_strobe    one-cycle request to XOR tgl into pattern[edit_idx]
//   mute          per-track trigger suppression
//   raw_trig      live pad inputs, rising edges trigger in RAW mode
//   step_idx      current play step
//   step_onehot   step 0 maps to the MSB
//   trig          registered one-cycle per-track trigger pulses
//   beat          registered one-cycle pulse at every step start
//   edit_row      combinational pattern[edit_idx], 0 when out of range
module step_sequencer #(
   parameter int unsigned STEPS   = 8,
   parameter int unsigned TRACKS  = 4,
   parameter int unsigned TEMPO_W = 8,
   localparam int unsigned IW     = $clog2(STEPS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   input  logic [TEMPO_W-1:0] tempo_lim,
   input  logic [IW:0]        seq_len,
   input  logic [IW-1:0]      edit_idx,
   input  logic [TRACKS-1:0]  tgl,
   input  logic               tgl_strobe,
   input  logic [TRACKS-1:0]  mute,
   input  logic [TRACKS-1:0]  raw_trig,
   output logic [IW-1:0]      step_idx,
   output logic [STEPS-1:0]   step_onehot,
   output logic [TRACKS-1:0]  trig,
   output logic               beat,
   output logic [TRACKS-1:0]  edit_row
);

   typedef enum logic [1:0] {ModeEdit, ModePlay, ModeRaw, ModePause} mode_t;

   localparam logic [IW:0] StepsW = STEPS[IW:0];

   mode_t               cur_mode;
   mode_t               prev_mode_q;
   logic [TRACKS-1:0]   pattern_q [STEPS];
   logic [TRACKS-1:0]   pattern_d [STEPS];
   logic [IW-1:0]       step_idx_q, step_idx_d;
   logic [TEMPO_W-1:0]  counter_q, counter_d;
   logic [TRACKS-1:0]   trig_q, trig_d;
   logic                beat_q, beat_d;
   logic [TRACKS-1:0]   raw_prev_q;

   logic                edit_ok;
   logic [IW:0]         eff_len;
   logic [IW-1:0]       next_idx;

   assign cur_mode = mode_t'(mode);
   assign edit_ok  = ({1'b0, edit_idx} < StepsW);

   // Zero or oversized lengths fall back to the full pattern.
   assign eff_len  = (seq_len == '0 || seq_len > StepsW) ? StepsW : seq_len;

   // >= rather than == so a length shrunk below the current step wraps at once.
   assign next_idx = ({1'b0, step_idx_q} >= (eff_len - (IW+1)'(1))) ? '0
                                                                     : step_idx_q + IW'(1);

   always_comb begin
      pattern_d  = pattern_q;
      step_idx_d = step_idx_q;
      counter_d  = counter_q;
      trig_d     = '0;
      beat_d     = 1'b0;

      if (tgl_strobe && edit_ok && (cur_mode == ModeEdit || cur_mode == ModePlay)) begin
         pattern_d[edit_idx] = pattern_q[edit_idx] ^ tgl;
      end

      // Triggers read pattern_q, so an edit landing on the same edge is not seen.
      unique case (cur_mode)
         ModePlay: begin
            if (prev_mode_q != ModePlay) begin
               step_idx_d = '0;
               counter_d  = '0;
               trig_d     = pattern_q[0] & ~mute;
               beat_d     = 1'b1;
            end else if (counter_q >= tempo_lim) begin
               step_idx_d = next_idx;
               counter_d  = '0;
               trig_d     = pattern_q[next_idx] & ~mute;
               beat_d     = 1'b1;
            end else begin
               counter_d  = counter_q + TEMPO_W'(1);
            end
         end
         ModeRaw: begin
            trig_d = raw_trig & ~raw_prev_q & ~mute;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STEPS; i++) begin
            pattern_q[i] <= '0;
         end
         step_idx_q  <= '0;
         counter_q   <= '0;
         trig_q      <= '0;
         beat_q      <= 1'b0;
         prev_mode_q <= ModeEdit;
         raw_prev_q  <= '0;
      end else begin
         pattern_q   <= pattern_d;
         step_idx_q  <= step_idx_d;
         counter_q   <= counter_d;
         trig_q      <= trig_d;
         beat_q      <= beat_d;
         prev_mode_q <= cur_mode;
         raw_prev_q  <= raw_trig;
      end
   end

   always_comb begin
      step_onehot = '0;
      for (int i = 0; i < STEPS; i++) begin
         step_onehot[STEPS-1-i] = (step_idx_q == IW'(i));
      end
   end

   assign step_idx = step_idx_q;
   assign trig     = trig_q;
   assign beat     = beat_q;
   assign edit_row = edit_ok ? pattern_q[edit_idx] : '0;

endmodule
